// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator with a valid/ready handshake, an output
// register plus a one-entry skid, and a saturating illegal-opcode counter.
// Optional feature macro: IMM_GEN_SHAMT_EN (zero-extended shamt for slli/srli/srai).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;

  // NOTE: every variable gets a default before the case, so no latch is inferred.
  always_comb begin
    dec_imm32 = '0;
    dec_fmt   = FMT_R;
    dec_ill   = 1'b0;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
`ifdef IMM_GEN_SHAMT_EN
        // funct3 001 / 101 on OP-IMM are the shifts; bit 31 stays 0 so sign-extension is zero-extension
        if (in_instr[6:0] == 7'b0010011 && in_instr[13:12] == 2'b01)
          dec_imm32 = (XLEN == 64) ? {26'd0, in_instr[25:20]} : {27'd0, in_instr[24:20]};
`endif
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011: dec_fmt = FMT_R;
      default: begin
        dec_fmt = FMT_ILL;
        dec_ill = 1'b1;
      end
    endcase
  end

  assign dec_imm = XLEN'($signed(dec_imm32));

  logic            o_valid, s_free;
  logic [XLEN-1:0] o_imm, s_imm;
  fmt_e            o_fmt, s_fmt;
  logic            o_ill, s_ill;
  logic [CNT_W-1:0] cnt;
  logic            accept, o_free;

  assign accept = in_valid & s_free & ~flush;
  assign o_free = ~o_valid | out_ready;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: payload registers are reset too, because the outputs must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_imm   <= '0;
      o_fmt   <= FMT_R;
      o_ill   <= 1'b0;
      s_free  <= 1'b1;
      s_imm   <= '0;
      s_fmt   <= FMT_R;
      s_ill   <= 1'b0;
    end else if (flush) begin
      o_valid <= 1'b0;
      s_free  <= 1'b1;
    end else if (o_free) begin
      if (!s_free) begin
        o_valid <= 1'b1;
        o_imm   <= s_imm;
        o_fmt   <= s_fmt;
        o_ill   <= s_ill;
        s_free  <= 1'b1;
      end else if (accept) begin
        o_valid <= 1'b1;
        o_imm   <= dec_imm;
        o_fmt   <= dec_fmt;
        o_ill   <= dec_ill;
      end else begin
        o_valid <= 1'b0;
      end
    end else if (accept) begin
      // O is stalled, so the new entry parks in the skid and in_ready drops next cycle
      s_free <= 1'b0;
      s_imm  <= dec_imm;
      s_fmt  <= dec_fmt;
      s_ill  <= dec_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (accept && dec_ill && cnt != {CNT_W{1'b1}})
      cnt <= cnt + CNT_W'(1);
  end

  assign in_ready    = s_free;
  assign out_valid   = o_valid;
  assign out_imm     = o_imm;
  assign out_fmt     = o_fmt;
  assign out_illegal = o_ill;
  assign illegal_cnt = cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: a scoreboard of expected results for
// the XLEN=32/CNT_W=2 instance plus directed checks, and one XLEN=64 instance.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [1:0]  illegal_cnt;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [7:0]  illegal_cnt64;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .illegal_cnt(illegal_cnt64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    e.imm = 32'd0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: begin
        e.fmt = 3'd1;
        e.imm = {{20{i[31]}}, i[31:20]};
`ifdef IMM_GEN_SHAMT_EN
        if (i[6:0] == 7'h13 && (i[14:12] == 3'b001 || i[14:12] == 3'b101))
          e.imm = {27'd0, i[24:20]};
`endif
      end
      7'h23: begin e.fmt = 3'd2; e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
      7'h63: begin e.fmt = 3'd3; e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = {i[31:12], 12'h000}; end
      7'h6F: begin e.fmt = 3'd5; e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
      7'h33: e.fmt = 3'd0;
      default: begin e.fmt = 3'd7; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // Scoreboard: compare on output fire, push on input fire, drop everything on flush/reset.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_imm", 64'(out_imm), 64'(e.imm));
          check("sb_fmt", 64'(out_fmt), 64'(e.fmt));
          check("sb_ill", 64'(out_illegal), 64'(e.ill));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_instr));
    end else begin
      sb.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] imm,
                            input logic [2:0] fmt);
    check({tag, "_valid"}, 64'(out_valid), 64'(v));
    check({tag, "_imm"}, 64'(out_imm), 64'(imm));
    check({tag, "_fmt"}, 64'(out_fmt), 64'(fmt));
  endtask

  initial begin
    logic [31:0] ill_words [5];
    logic [1:0]  ill_cnts  [5];
    ill_words = '{32'h0000007F, 32'hFFFFFFFF, 32'h1234567F, 32'h8000007F, 32'h0000107F};
    ill_cnts  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 32'd0, 3'd0);
    check("reset_illegal", 64'(out_illegal), 64'd0);
    check("reset_cnt", 64'(illegal_cnt), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    tick;

    // single addi -1, one-cycle latency
    in_valid = 1'b1; in_instr = 32'hFFF00093;
    tick;
    expect_out("addi", 1'b1, 32'hFFFFFFFF, 3'd1);

    // back-to-back stream at full rate
    in_instr = 32'hFE112E23;
    tick;
    expect_out("stream_s", 1'b1, 32'hFFFFFFFC, 3'd2);
    in_instr = 32'h123450B7;
    tick;
    expect_out("stream_u", 1'b1, 32'h12345000, 3'd4);
    check("stream_in_ready", 64'(in_ready), 64'd1);
    in_instr = 32'hFFDFF0EF;
    tick;
    expect_out("stream_j", 1'b1, 32'hFFFFFFFC, 3'd5);
    in_instr = 32'h002081B3;
    tick;
    expect_out("stream_r", 1'b1, 32'd0, 3'd0);
    in_valid = 1'b0;
    tick;
    check("drained_valid", 64'(out_valid), 64'd0);

    // backpressure: O then S fill, third word is refused
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500113;
    tick;
    expect_out("bp_o", 1'b1, 32'd5, 3'd1);
    check("bp_in_ready_1", 64'(in_ready), 64'd1);
    in_instr = 32'h80000063;
    tick;
    check("bp_in_ready_0", 64'(in_ready), 64'd0);
    expect_out("bp_hold1", 1'b1, 32'd5, 3'd1);
    in_instr = 32'h7E000FA3;
    tick;
    expect_out("bp_hold2", 1'b1, 32'd5, 3'd1);
    check("bp_in_ready_hold", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick;
    expect_out("bp_drain_b", 1'b1, 32'hFFFFF000, 3'd3);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    tick;
    expect_out("bp_drain_s", 1'b1, 32'h000007FF, 3'd2);
    in_valid = 1'b0;
    tick;
    check("bp_empty", 64'(out_valid), 64'd0);

    // shift-immediate handling
    in_valid = 1'b1; in_instr = 32'h4030D093;
    tick;
`ifdef IMM_GEN_SHAMT_EN
    expect_out("srai", 1'b1, 32'h00000003, 3'd1);
`else
    expect_out("srai", 1'b1, 32'h00000403, 3'd1);
`endif
    in_valid = 1'b0;
    tick;

    // flush with O and S full, then flush while an illegal word could be accepted
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
    tick;
    in_instr = 32'h00200093;
    tick;
    check("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1; in_instr = 32'h0000007F;
    tick;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_cnt", 64'(illegal_cnt), 64'd0);
    tick;
    check("fl2_valid", 64'(out_valid), 64'd0);
    check("fl2_cnt", 64'(illegal_cnt), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick;
    check("fl_no_stale", 64'(out_valid), 64'd0);

    // illegal opcodes with a 2-bit saturating counter
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_instr = ill_words[i];
      tick;
      expect_out($sformatf("ill%0d", i), 1'b1, 32'd0, 3'd7);
      check($sformatf("ill%0d_flag", i), 64'(out_illegal), 64'd1);
      check($sformatf("ill%0d_cnt", i), 64'(illegal_cnt), 64'(ill_cnts[i]));
    end
    in_valid = 1'b0;
    tick;

    // reset in mid-transfer
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000007F;
    tick;
    in_instr = 32'hFFDFF0EF;
    tick;
    rst_n = 1'b0; in_instr = 32'h00100093;
    tick;
    expect_out("mrst", 1'b0, 32'd0, 3'd0);
    check("mrst_illegal", 64'(out_illegal), 64'd0);
    check("mrst_cnt", 64'(illegal_cnt), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick;
    tick;
    check("mrst_no_late", 64'(out_valid), 64'd0);

    // lui with bit 31 set on both widths
    in_valid = 1'b1; in_instr = 32'h800000B7;
    tick;
    expect_out("lui32", 1'b1, 32'h80000000, 3'd4);
    check("lui64_valid", 64'(out_valid64), 64'd1);
    check("lui64_imm", out_imm64, 64'hFFFFFFFF80000000);
    check("lui64_fmt", 64'(out_fmt64), 64'd4);
    in_valid = 1'b0;
    tick;
    tick;

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
